// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle add/compare/op0, iterative shift-add multiply (op 0 selected by ALU_SUB_EN: subtract when defined, pass in1 otherwise)
module alu_seq #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] out,
  output logic              z,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam logic [1:0] OP_ZERO = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_LT   = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_mul_last;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out;
  logic              r_z;
  logic              r_done;
  logic [DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0] w_op0_res;

`ifdef ALU_SUB_EN
  assign w_op0_res = in1 - in2;
`else
  assign w_op0_res = in1;
`endif

  // Partial-product accumulate for the current multiplier bit; upper bits fall off.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake decode; start is only honoured in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mul_last   = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = start;
        if (start && (alu_op == OP_MUL)) begin
          w_state_next = MUL;
        end
      end
      MUL: begin
        w_mul_last = (r_cnt == LAST_CNT);
        if (w_mul_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iteration, result/flag/done registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_z      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        case (alu_op)
          OP_ZERO: begin
            r_out  <= w_op0_res;
            r_done <= 1'b1;
          end
          OP_ADD: begin
            r_out  <= in1 + in2;
            r_done <= 1'b1;
          end
          OP_LT: begin
            r_z    <= (in1 < in2);
            r_done <= 1'b1;
          end
          default: begin
            r_acc    <= '0;
            r_mcand  <= in1;
            r_mplier <= in2;
            r_cnt    <= '0;
          end
        endcase
      end else if (r_state == MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_mul_last) begin
          r_out  <= w_acc_next;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign out  = r_out;
  assign z    = r_z;
  assign busy = (r_state == MUL);
  assign done = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (DATA_W=16, honours ALU_SUB_EN)
module tb_alu_seq;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  alu_op;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] out;
  logic        z;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;
  int lat;
  int n_busy;
  int n_done;

  alu_seq #(.DATA_W(16), .CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .alu_op  (alu_op),
    .in1     (in1),
    .in2     (in2),
    .out     (out),
    .z       (z),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one op for a single edge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    start  = 1'b1;
    alu_op = op;
    in1    = a;
    in2    = b;
    tick();
    start  = 1'b0;
  endtask

  // Multiply already accepted: wait for done, optionally injecting starts mid-run.
  task automatic wait_mul(input bit inject);
    lat    = 0;
    n_busy = 0;
    n_done = 0;
    if (busy) n_busy++;
    for (int k = 1; k <= 40; k++) begin
      if (inject && (k == 3 || k == 8)) begin
        start = 1'b1; alu_op = 2'd1; in1 = 16'd1; in2 = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        n_done++;
        lat = k;
        break;
      end
      if (busy) n_busy++;
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    alu_op   = 2'd0;
    in1      = '0;
    in2      = '0;
    tick();
    tick();
    check("rst_out", out, 0);
    check("rst_z", z, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    // add with wrap
    issue(2'd1, 16'hFFFF, 16'h0002);
    check("add_wrap_out", out, 16'h0001);
    check("add_wrap_done", done, 1);
    check("add_wrap_z", z, 0);
    tick();
    check("add_done_clear", done, 0);

    // compare
    issue(2'd2, 16'd3, 16'd5);
    check("lt_z1", z, 1);
    check("lt_out_hold", out, 16'h0001);
    check("lt_done", done, 1);
    issue(2'd2, 16'd5, 16'd5);
    check("lt_eq_z0", z, 0);

    // single-cycle ops every cycle
    issue(2'd1, 16'd2, 16'd3);
    check("b2b_add1", out, 16'd5);
    issue(2'd1, 16'd4, 16'd4);
    check("b2b_add2", out, 16'd8);
    check("b2b_done", done, 1);

    // op 0 per build
    issue(2'd0, 16'd10, 16'd4);
`ifdef ALU_SUB_EN
    check("op0_sub", out, 16'd6);
    issue(2'd0, 16'd0, 16'd1);
    check("op0_sub_wrap", out, 16'hFFFF);
`else
    check("op0_pass", out, 16'd10);
`endif

    // multiply 300*250 = 75000 mod 65536 = 9464
    issue(2'd3, 16'd300, 16'd250);
    check("mul_busy_T", busy, 1);
    check("mul_done_T", done, 0);
    wait_mul(1'b0);
    check("mul_lat", lat, 16);
    check("mul_busy_cycles", n_busy, 16);
    check("mul_out", out, 16'd9464);
    check("mul_busy_end", busy, 0);
    check("mul_z_hold", z, 0);
    // start while done is high: accepted at T+DATA_W+1
    issue(2'd1, 16'd7, 16'd8);
    check("post_mul_add", out, 16'd15);
    check("post_mul_done", done, 1);

    // multiply by zero, full latency
    issue(2'd3, 16'd1234, 16'd0);
    wait_mul(1'b0);
    check("mul0_lat", lat, 16);
    check("mul0_out", out, 16'd0);

    // max operands: 0xFFFF*0xFFFF low half = 1
    issue(2'd3, 16'hFFFF, 16'hFFFF);
    wait_mul(1'b0);
    check("mulmax_out", out, 16'h0001);

    // ignored starts and operand changes during multiply: 123*45 = 5535
    issue(2'd3, 16'd123, 16'd45);
    wait_mul(1'b1);
    check("ign_lat", lat, 16);
    check("ign_ndone", n_done, 1);
    check("ign_out", out, 16'd5535);
    tick();
    check("ign_no_extra_done", done, 0);
    check("ign_out_hold", out, 16'd5535);

    // reset mid-multiply
    issue(2'd2, 16'd1, 16'd2);
    check("pre_rst_z", z, 1);
    issue(2'd3, 16'd7, 16'd9);
    for (int k = 0; k < 5; k++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_out", out, 0);
    check("mrst_z", z, 0);
    check("mrst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) n_done++;
    end
    check("mrst_no_done", n_done, 0);
    check("mrst_out_after", out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
